ex_muldiv_unit: RTL and testbench
=================================

Name: ex_muldiv_unit

Overview:
- Multi-cycle multiply/divide execute unit that consumes operands and control from the ID/EX pipeline register outputs.
- Raises a stall so the IF/ID and ID/EX registers hold while it iterates.
- Returns a 32-bit result with its destination register address for the EX/MEM stage.
- Implements iterative shift-add multiply and restoring divide, all unsigned.

Parameters:
- WIDTH, 32, operand and result width
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
- clk_i  in  1  clock, all state changes on rising edge
- rst_i  in  1  synchronous reset, active-high
- start_i  in  1  muldiv instruction present at ID/EX output (from ID_EX control)
- op_i  in  2  operation: 0 MUL, 1 MULHU, 2 DIVU, 3 REMU
- rs_data_i  in  WIDTH  operand A (ID/EX RSdata)
- rt_data_i  in  WIDTH  operand B (ID/EX RTdata)
- rd_addr_i  in  5  destination register (ID/EX RDaddr)
- flush_i  in  1  pipeline flush; aborts the operation in progress
- stall_o  out  1  hold request to the PC, IF/ID and ID/EX registers
- done_o  out  1  result valid, one-cycle pulse
- result_o  out  WIDTH  operation result
- rd_addr_o  out  5  destination register of the result
- busy_o  out  1  state != IDLE

Behaviour:
- Reset (rst_i=1 at an edge): state IDLE, counter 0, all internal registers 0. stall_o=0, done_o=0, result_o=0, rd_addr_o=0, busy_o=0. Reset overrides flush_i and start_i and aborts any operation in progress.
- States: IDLE, BUSY, DONE.
- IDLE:
  - stall_o = start_i (combinational), so the ID/EX register holds the instruction in the accept cycle.
  - At an edge with start_i=1 and flush_i=0: latch op_i, rs_data_i, rt_data_i, rd_addr_i; counter=0; go to BUSY.
- BUSY:
  - stall_o=1. One iteration per edge; after WIDTH iterations (counter reaches WIDTH-1 and increments) go to DONE.
  - Total: accept at edge E0; iterations at E1..E32; DONE entered at E32; done_o high for the cycle E32..E33. Latency is 33 cycles from accept to done_o, fixed for every op and every operand value.
- Multiply: 2*WIDTH-bit product register; each iteration adds the multiplicand if the current multiplier LSB is 1, then shifts right. MUL returns the low WIDTH bits; MULHU returns the high WIDTH bits.
- Divide (restoring): each iteration shifts {remainder, quotient} left by 1; trial subtract the divisor; if no borrow, commit the subtraction and set quotient LSB to 1. DIVU returns the quotient; REMU returns the remainder.
- Divide by zero needs no special case: the algorithm naturally yields quotient 0xFFFFFFFF and remainder = dividend, and still takes 33 cycles.
- DONE:
  - done_o=1, stall_o=0 (the pipeline advances past the instruction).
  - result_o and rd_addr_o are valid; they are registered and held until the next DONE or reset.
  - Next edge: go to IDLE unconditionally. start_i sampled in DONE is ignored, because it still reflects the completing instruction.
- Back-to-back: the earliest next accept is the edge after returning to IDLE, i.e. one idle cycle between ops.
- flush_i at an edge:
  - In BUSY or DONE: go to IDLE, no done_o pulse follows, result_o keeps its previous value.
  - In IDLE: blocks the accept.
- stall_o never asserts while rst_i=1 or flush_i=1.
- done_o is never high in the same cycle as stall_o.

Decomposition:
- Shared package (cpu_pkg): op encodings MD_MUL=2'd0, MD_MULHU=2'd1, MD_DIVU=2'd2, MD_REMU=2'd3; state encoding; WIDTH default.
- One natural sub-module, muldiv_datapath: iteration register plus add/subtract step, with no FSM. The top level holds the FSM, counter and result/rd registers.

Test Plan:
- MUL 7*9, rd=5: stall_o high from the accept cycle for 33 cycles, then done_o for exactly one cycle with result_o=63 and rd_addr_o=5.
- MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MUL with the same operands -> 0x00000001.
- DIVU 100/7 -> 14 and REMU 100/7 -> 2; DIVU 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5; all at 33-cycle latency.
- flush_i pulsed in iteration 10: state IDLE the next cycle, stall_o=0, no done_o; a new MUL 3*4 accepted afterwards returns 12.
- rst_i asserted mid-BUSY: all outputs 0 at the next cycle, busy_o=0, and no done_o for the aborted op.
- start_i held high continuously across two instructions: exactly one done_o per accept, with the start_i seen in DONE ignored; the second op is accepted only after one IDLE cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// ============================================================================
// Module  : cpu_pkg
// Purpose : Shared encodings for the multi-cycle multiply/divide execute unit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [1:0] MD_MUL   = 2'd0;
  localparam logic [1:0] MD_MULHU = 2'd1;
  localparam logic [1:0] MD_DIVU  = 2'd2;
  localparam logic [1:0] MD_REMU  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

endpackage

`default_nettype wire

// File: rtl/muldiv_datapath.sv
// ============================================================================
// Module  : muldiv_datapath
// Purpose : 2*WIDTH iteration register with shift-add multiply and restoring
//           divide step. No control state; the parent sequences load/step.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_datapath
  import cpu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic                 step_i,
  input  logic                 div_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic [2*WIDTH-1:0]   acc_o,
  output logic [2*WIDTH-1:0]   acc_next_o
);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q;
  logic               div_q;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH+1:0]   diff;
  logic [2*WIDTH-1:0] step_val;

  always_comb begin
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
              (acc_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
    // Remainder keeps the bit shifted out of the top so the trial compare is exact.
    rem_sh  = acc_q[2*WIDTH-1:WIDTH-1];
    diff    = {1'b0, rem_sh} - {2'b00, opb_q};
    if (div_q) begin
      if (!diff[WIDTH+1]) step_val = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      else                step_val = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end else begin
      step_val = {mul_sum, acc_q[WIDTH-1:1]};
    end

    acc_d = acc_q;
    if (load_i)      acc_d = {{WIDTH{1'b0}}, a_i};
    else if (step_i) acc_d = step_val;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q <= '0;
      opb_q <= '0;
      div_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      if (load_i) begin
        opb_q <= b_i;
        div_q <= div_i;
      end
    end
  end

  assign acc_o      = acc_q;
  assign acc_next_o = acc_d;

endmodule

`default_nettype wire

// File: rtl/ex_muldiv_unit.sv
// ============================================================================
// Module  : ex_muldiv_unit
// Purpose : Multi-cycle unsigned MUL/MULHU/DIVU/REMU execute unit with
//           pipeline stall, flush abort and registered result/rd outputs.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_muldiv_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] rs_data_i,
  input  logic [WIDTH-1:0] rt_data_i,
  input  logic [4:0]       rd_addr_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic [4:0]       rd_addr_o,
  output logic             busy_o
);

  md_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sel_hi_q, sel_hi_d;
  logic [4:0]        rd_q, rd_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic [4:0]        rd_out_q, rd_out_d;

  logic               load, step, last;
  logic [2*WIDTH-1:0] acc, acc_next;

  assign last = (cnt_q == CNT_W'(WIDTH-1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sel_hi_d = sel_hi_q;
    rd_d     = rd_q;
    result_d = result_q;
    rd_out_d = rd_out_q;
    load     = 1'b0;
    step     = 1'b0;
    stall_o  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        stall_o = start_i && !flush_i && !rst_i;
        if (start_i && !flush_i) begin
          load     = 1'b1;
          sel_hi_d = op_i[0];
          rd_d     = rd_addr_i;
          cnt_d    = '0;
          state_d  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        stall_o = !flush_i && !rst_i;
        if (flush_i) begin
          state_d = ST_IDLE;
        end else begin
          step  = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
          if (last) begin
            // MUL/DIVU take the low half, MULHU/REMU the high half.
            result_d = sel_hi_q ? acc_next[2*WIDTH-1:WIDTH] : acc_next[WIDTH-1:0];
            rd_out_d = rd_q;
            state_d  = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      sel_hi_q <= 1'b0;
      rd_q     <= '0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_hi_q <= sel_hi_d;
      rd_q     <= rd_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
    end
  end

  muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (load),
    .step_i     (step),
    .div_i      (op_i[1]),
    .a_i        (rs_data_i),
    .b_i        (rt_data_i),
    .acc_o      (acc),
    .acc_next_o (acc_next)
  );

  logic unused_acc;
  assign unused_acc = ^acc;

  assign done_o    = (state_q == ST_DONE);
  assign busy_o    = (state_q != ST_IDLE);
  assign result_o  = result_q;
  assign rd_addr_o = rd_out_q;

endmodule

`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
// ============================================================================
// Module  : tb_ex_muldiv_unit
// Purpose : Scoreboard bench for ex_muldiv_unit with directed vectors.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_muldiv_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i, start_i, flush_i;
  logic [1:0]  op_i;
  logic [31:0] rs_data_i, rt_data_i;
  logic [4:0]  rd_addr_i;
  logic        stall_o, done_o, busy_o;
  logic [31:0] result_o;
  logic [4:0]  rd_addr_o;

  ex_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
    .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .rd_addr_i(rd_addr_i),
    .flush_i(flush_i), .stall_o(stall_o), .done_o(done_o),
    .result_o(result_o), .rd_addr_o(rd_addr_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done_o pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done_o && stall_o) begin
      errors++;
      $display("FAIL done_stall_overlap: done_o and stall_o both high (cycle %0d)", cyc);
    end
    if (done_o) begin
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: result 0x%08h rd %0d with no op pending (cycle %0d)",
                 result_o, rd_addr_o, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", result_o, e.res);
        chk("rd_addr", {27'd0, rd_addr_o}, {27'd0, e.rd});
        chk("done_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    op_i = op; rs_data_i = a; rt_data_i = b; rd_addr_i = rd;
  endtask

  // Issue one op, check the 33-cycle stall window and wait for done_o.
  task automatic do_op(input string name, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
    int n_stall;
    int k;
    @(negedge clk);
    start_i = 1'b1;
    drive(op, a, b, rd);
    #1;
    chk({name, "_accept_stall"}, {31'd0, stall_o}, 32'd1);
    sb.push_back('{exp, rd, cyc + 1 + 32});
    @(negedge clk);
    start_i = 1'b0;
    n_stall = 0;
    k = 0;
    while (!done_o && k < 40) begin
      if (stall_o) n_stall++;
      k++;
      @(negedge clk);
    end
    chk({name, "_busy_stall_cycles"}, n_stall, 32'd32);
    chk({name, "_done_seen"}, {31'd0, done_o}, 32'd1);
  endtask

  initial begin
    int k;
    rst_i = 1'b1; start_i = 1'b0; flush_i = 1'b0;
    drive(MD_MUL, 32'd0, 32'd0, 5'd0);
    repeat (3) @(negedge clk);
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_result", result_o, 32'd0);
    chk("rst_rd", {27'd0, rd_addr_o}, 32'd0);
    rst_i = 1'b0;

    do_op("mul7x9",    MD_MUL,   32'd7,        32'd9,        5'd5,  32'd63);
    do_op("mulhu_max", MD_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'hFFFFFFFE);
    do_op("mul_max",   MD_MUL,   32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'h00000001);
    do_op("divu100_7", MD_DIVU,  32'd100,      32'd7,        5'd8,  32'd14);
    do_op("remu100_7", MD_REMU,  32'd100,      32'd7,        5'd9,  32'd2);
    do_op("divu5_0",   MD_DIVU,  32'd5,        32'd0,        5'd10, 32'hFFFFFFFF);
    do_op("remu5_0",   MD_REMU,  32'd5,        32'd0,        5'd11, 32'd5);

    // Flush during iteration 10: no done_o, result unchanged.
    @(negedge clk);
    start_i = 1'b1;
    drive(MD_MUL, 32'd11, 32'd13, 5'd12);
    @(negedge clk);
    start_i = 1'b0;
    repeat (9) @(negedge clk);
    flush_i = 1'b1;
    #1;
    chk("flush_stall_low", {31'd0, stall_o}, 32'd0);
    @(negedge clk);
    flush_i = 1'b0;
    chk("flush_busy", {31'd0, busy_o}, 32'd0);
    chk("flush_stall", {31'd0, stall_o}, 32'd0);
    chk("flush_result_kept", result_o, 32'd5);
    repeat (40) @(negedge clk);
    do_op("mul3x4", MD_MUL, 32'd3, 32'd4, 5'd3, 32'd12);

    // Reset mid-BUSY clears everything.
    @(negedge clk);
    start_i = 1'b1;
    drive(MD_DIVU, 32'd1000, 32'd3, 5'd20);
    @(negedge clk);
    start_i = 1'b0;
    repeat (4) @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    chk("midrst_busy", {31'd0, busy_o}, 32'd0);
    chk("midrst_stall", {31'd0, stall_o}, 32'd0);
    chk("midrst_done", {31'd0, done_o}, 32'd0);
    chk("midrst_result", result_o, 32'd0);
    chk("midrst_rd", {27'd0, rd_addr_o}, 32'd0);
    rst_i = 1'b0;
    repeat (40) @(negedge clk);

    // start_i held across two instructions; start seen in DONE is ignored.
    @(negedge clk);
    start_i = 1'b1;
    drive(MD_MUL, 32'd2, 32'd3, 5'd1);
    sb.push_back('{32'd6, 5'd1, cyc + 1 + 32});
    sb.push_back('{32'd10, 5'd2, cyc + 1 + 34 + 32});
    k = 0;
    @(negedge clk);
    while (!done_o && k < 40) begin k++; @(negedge clk); end
    chk("held_first_done", {31'd0, done_o}, 32'd1);
    drive(MD_DIVU, 32'd50, 32'd5, 5'd2);
    @(negedge clk);
    #1;
    chk("held_idle_busy", {31'd0, busy_o}, 32'd0);
    chk("held_idle_stall", {31'd0, stall_o}, 32'd1);
    k = 0;
    @(negedge clk);
    while (!done_o && k < 40) begin k++; @(negedge clk); end
    chk("held_second_done", {31'd0, done_o}, 32'd1);
    start_i = 1'b0;
    repeat (40) @(negedge clk);

    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
